// File: rtl/sys_defs.sv
// Shared core definitions: ALU function codes, sizing macros and the
// multiply-pipeline stage payload used by mult_unit and mult_stage.
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef INTM_GRP
`define INTM_GRP 3'h2
`endif

package sys_defs;

    localparam int PRF_SIZE    = `PRF_SIZE;
    localparam int ROB_SIZE    = `ROB_SIZE;
    localparam int MULT_STAGES = 4;

    typedef enum logic [4:0] {
        ALU_ADDQ  = 5'h00,
        ALU_SUBQ  = 5'h01,
        ALU_AND   = 5'h02,
        ALU_MULQ  = 5'h0b,
        ALU_MULL  = 5'h0c,
        ALU_UMULH = 5'h0d
    } ALU_FUNC;

    // Arithmetic payload carried down the pipeline; mcand is pre-shifted to
    // line up with the low multiplier bits still waiting in mplier.
    typedef struct packed {
        logic [127:0] prod;
        logic [127:0] mcand;
        logic [63:0]  mplier;
        ALU_FUNC      func;
    } mult_stage_t;

    function automatic logic [63:0] mult_format(input ALU_FUNC func, input logic [127:0] prod);
        case (func)
            ALU_MULQ:  mult_format = prod[63:0];
            ALU_UMULH: mult_format = prod[127:64];
            ALU_MULL:  mult_format = {{32{prod[31]}}, prod[31:0]};
            default:   mult_format = 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One registered partial-product step: folds CHUNK multiplier bits into the
// running product, then registers payload, tag and ROB index under hold/clear.
module mult_stage
    import sys_defs::*;
#(
    parameter int CHUNK = 16,
    parameter int TAG_W = 6,
    parameter int ROB_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  mult_stage_t      data_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [ROB_W-1:0] rob_i,
    output logic             valid_o,
    output mult_stage_t      data_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [ROB_W-1:0] rob_o
);

    logic             valid_q;
    mult_stage_t      data_q;
    mult_stage_t      data_d;
    logic [TAG_W-1:0] tag_q;
    logic [ROB_W-1:0] rob_q;

    always_comb begin
        data_d        = data_i;
        data_d.prod   = data_i.prod + data_i.mcand * 128'(data_i.mplier[CHUNK-1:0]);
        data_d.mcand  = data_i.mcand << CHUNK;
        data_d.mplier = data_i.mplier >> CHUNK;
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would ripple one op through
    // several stages in a single edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            rob_q   <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            tag_q   <= tag_i;
            rob_q   <= rob_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;
    assign rob_o   = rob_q;

endmodule

// File: rtl/mult_unit.sv
// Pipelined 64x64 integer multiply unit between the RS and the CDB arbiter.
// Optional early wakeup tag outputs are enabled by defining MULT_EARLY_TAG_EN.
module mult_unit
    import sys_defs::*;
#(
    parameter int NUM_STAGES = MULT_STAGES,
    parameter int TAG_W      = $clog2(PRF_SIZE),
    parameter int ROB_W      = $clog2(ROB_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_issue_valid,
    input  logic [63:0]      mult_opa_in,
    input  logic [63:0]      mult_opb_in,
    input  logic [TAG_W-1:0] mult_dest_tag_in,
    input  logic [ROB_W-1:0] mult_rob_idx_in,
    input  ALU_FUNC          mult_alu_func_in,
    input  logic             mult_flush,
    input  logic             cdb_grant,
    output logic             mult_available,
    output logic             mult_result_valid,
    output logic [63:0]      mult_result,
    output logic [TAG_W-1:0] mult_dest_tag_out,
    output logic [ROB_W-1:0] mult_rob_idx_out
`ifdef MULT_EARLY_TAG_EN
    ,
    output logic             mult_early_tag_valid,
    output logic [TAG_W-1:0] mult_early_tag
`endif
);

    localparam int CHUNK = 64 / NUM_STAGES;

    // Element 0 is the issue port; element k+1 is the register of stage k.
    logic             chain_valid [NUM_STAGES+1];
    mult_stage_t      chain_data  [NUM_STAGES+1];
    logic [TAG_W-1:0] chain_tag   [NUM_STAGES+1];
    logic [ROB_W-1:0] chain_rob   [NUM_STAGES+1];
    logic             stall;
    logic             unused_bits;

    assign stall          = mult_result_valid && !cdb_grant;
    assign mult_available = !stall;

    assign chain_valid[0] = mult_issue_valid && mult_available;
    assign chain_data[0]  = '{prod: '0, mcand: {64'd0, mult_opa_in}, mplier: mult_opb_in,
                              func: mult_alu_func_in};
    assign chain_tag[0]   = mult_dest_tag_in;
    assign chain_rob[0]   = mult_rob_idx_in;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            mult_stage #(
                .CHUNK(CHUNK),
                .TAG_W(TAG_W),
                .ROB_W(ROB_W)
            ) u_stage (
                .clock  (clock),
                .reset  (reset),
                .en_i   (mult_available),
                .clear_i(mult_flush),
                .valid_i(chain_valid[k]),
                .data_i (chain_data[k]),
                .tag_i  (chain_tag[k]),
                .rob_i  (chain_rob[k]),
                .valid_o(chain_valid[k+1]),
                .data_o (chain_data[k+1]),
                .tag_o  (chain_tag[k+1]),
                .rob_o  (chain_rob[k+1])
            );
        end
    endgenerate

    assign mult_result_valid = chain_valid[NUM_STAGES];
    assign mult_result       = mult_format(chain_data[NUM_STAGES].func, chain_data[NUM_STAGES].prod);
    assign mult_dest_tag_out = chain_tag[NUM_STAGES];
    assign mult_rob_idx_out  = chain_rob[NUM_STAGES];

    // The last stage's shifted operands are fully consumed by then.
    assign unused_bits = ^{chain_data[NUM_STAGES].mcand, chain_data[NUM_STAGES].mplier};

`ifdef MULT_EARLY_TAG_EN
    assign mult_early_tag_valid = chain_valid[NUM_STAGES-1] && !stall && !mult_flush;
    assign mult_early_tag       = chain_tag[NUM_STAGES-1];
`else
    // Without early wakeup, dependents are woken only by the CDB broadcast.
`endif

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Pipelined integer multiply functional unit directly downstream of the reservation station.
- Accepts one issued INTM_GRP instruction per cycle (opa/opb/dest tag/ROB index/ALU_FUNC).
- Multiplies across NUM_STAGES pipeline stages and presents the result, PRF tag and ROB index to the CDB arbiter under a valid/grant handshake.
- Drives mult_available back to the RS.

Parameters:
NUM_STAGES, 4, pipeline depth; each stage consumes 64/NUM_STAGES multiplier bits; legal values are 2, 4 and 8.
TAG_W, $clog2(`PRF_SIZE), physical register tag width.
ROB_W, $clog2(`ROB_SIZE), ROB index width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mult_issue_valid  in  1  RS issues an instruction this cycle (RS rs_out_valid gated by op type).
mult_opa_in  in  64  multiplicand.
mult_opb_in  in  64  multiplier.
mult_dest_tag_in  in  TAG_W  destination PRF tag.
mult_rob_idx_in  in  ROB_W  ROB index.
mult_alu_func_in  in  ALU_FUNC  ALU_MULQ, ALU_MULL or ALU_UMULH.
mult_flush  in  1  branch-mispredict squash.
cdb_grant  in  1  arbiter accepts the result this cycle.
mult_available  out  1  unit can accept an issue this cycle (to RS).
mult_result_valid  out  1  result held for the CDB.
mult_result  out  64  product.
mult_dest_tag_out  out  TAG_W  tag for CDB broadcast.
mult_rob_idx_out  out  ROB_W  ROB index for completion.

Behaviour:
- Reset (reset==0, asynchronous): all stage valid bits = 0; all data/tag/idx registers = 0. Outputs: mult_result_valid=0, mult_result=0, mult_dest_tag_out=0, mult_rob_idx_out=0, mult_available=1.
- Stage k holds {valid, partial product (128b), multiplicand shifted, remaining multiplier bits, tag, rob idx, func}.
- Stage 0 captures the input when mult_issue_valid && mult_available, and adds the first partial product combinationally before the register.
- stall = mult_result_valid && !cdb_grant. When stall=1 every stage holds its contents. There is no bubble squeezing: the whole pipeline freezes.
- mult_available = !stall (combinational). An issue while mult_available=0 is ignored; RS must not issue then.
- Latency: an instruction issued at edge N drives mult_result_valid=1 after edge N+NUM_STAGES-1, i.e. NUM_STAGES cycles from issue to result. Throughput is 1 per cycle when cdb_grant is held high.
- Result held stable (value, tag, idx) until the cycle cdb_grant=1; it retires on that edge.
- Arithmetic: unsigned 64x64 -> 128-bit product.
  - ALU_MULQ: product[63:0].
  - ALU_UMULH: product[127:64].
  - ALU_MULL: sign-extend product[31:0] to 64 bits.
  - Any other func: result 0, still tagged and completed.
- Flush: mult_flush=1 clears every valid bit on the next edge, including a stalled output. An issue in the same cycle as a flush is dropped. Flush takes priority over grant and issue.
- Simultaneous grant and issue: the last stage retires, all stages shift, and the new instruction enters stage 0 in the same edge.
- Reset mid-operation: all in-flight work is lost; no CDB output is produced for it.

Optional Feature:
MULT_EARLY_TAG_EN:
- Defined: adds outputs mult_early_tag_valid (1) and mult_early_tag (TAG_W), driven from stage NUM_STAGES-2. They are valid one cycle before mult_result_valid so the RS can wake dependents early. Suppressed (valid=0) while stall=1 or mult_flush=1.
- Undefined: these ports do not exist; wakeup comes only through the CDB.

Decomposition:
- Shared package (sys_defs): ALU_FUNC enum (ALU_MULQ, ALU_MULL, ALU_UMULH), `PRF_SIZE, `ROB_SIZE, `INTM_GRP.
- New: a MULT_STAGES default constant, and a packed struct mult_stage_t for the per-stage payload.
- One sub-module: mult_stage. It is a single registered partial-product stage with a hold/enable input and a clear input, instantiated NUM_STAGES times via generate.

Test Plan:
1. Reset low mid-stream with 2 instructions in flight -> all outputs 0 immediately, mult_available=1, and no result ever appears.
2. Issue MULQ opa=32, opb=26, tag=1, rob=0, cdb_grant=1 -> exactly 4 cycles later result_valid=1, result=832, tag=1, rob=0 for one cycle.
3. Back-to-back MULQ (828*255, tag 0x28) then UMULH (0xFFFF_FFFF_FFFF_FFFF * 2) -> results 211140, then 1 on consecutive cycles.
4. MULL opa=0x0000_0000_8000_0000, opb=1 -> result 0xFFFF_FFFF_8000_0000.
5. cdb_grant=0 held for 3 cycles at result time -> result/tag stable, mult_available=0 throughout, second in-flight op does not advance. Grant for 1 cycle -> second result follows next cycle.
6. Flush with 3 in flight plus a concurrent issue -> no result_valid on any following cycle, mult_available=1 after the flush edge.
